// File: rtl/oam_dma_engine_pkg.sv
// Shared definitions for the OAM DMA engine: default geometry, FSM state
// encoding and the WRAM echo page mapping helper.
package oam_dma_engine_pkg;

    // Default transfer geometry: OAM starts at FE00, 160 bytes per copy.
    localparam logic [15:0]  OAM_LO      = 16'hFE00;
    localparam int unsigned  OAM_DMA_LEN = 160;

    // Encodings kept identical to the legacy memdef values.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        XFER    = 3'd2,
        DRAIN   = 3'd3,
        DONE_ST = 3'd4
    } dma_state_t;

    // Pages E0..FF mirror WRAM at C0..DF.
    function automatic logic [7:0] echo_map(input logic [7:0] page);
        return (page >= 8'hE0) ? (page - 8'h20) : page;
    endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA bus master. A write to the DMA register latches a source page and
// copies XFER_LEN bytes from {page,00} to DEST_BASE, one byte per cycle, with
// the read of byte k overlapped with the write of byte k-1.
// Optional build macro: OAM_DMA_ECHO_MAP_EN (maps source pages E0..FF onto
// C0..DF on the read address; the register readback stays raw).
module oam_dma_engine
    import oam_dma_engine_pkg::*;
#(
    parameter int unsigned XFER_LEN    = OAM_DMA_LEN,
    parameter logic [15:0] DEST_BASE   = OAM_LO,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_DMA_REG_WE_L,
    input  logic [7:0]  I_DMA_REG_DATA,
    output logic [7:0]  O_DMA_REG_DATA,
    output logic [15:0] O_RDMA_ADDR,
    output logic        O_RDMA_RE_L,
    input  logic [7:0]  I_RDMA_DATA,
    output logic [15:0] O_WDMA_ADDR,
    output logic [7:0]  O_WDMA_DATA,
    output logic        O_WDMA_WE_L,
    output logic        O_DMA_BUSY,
    output logic        O_DMA_DONE
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
    localparam logic [1:0] DLY_LAST = 2'(START_DELAY - 1);

    dma_state_t state, state_n;
    logic [7:0] idx, idx_n;        // index of the byte being read
    logic [1:0] dly_cnt, dly_n;    // START wait counter
    logic [7:0] src_hi;            // raw page as written by the CPU
    logic       wr_vld, wr_vld_n;  // a read was issued last cycle
    logic [7:0] wr_idx, wr_idx_n;  // index of that read (write pipeline)
    logic [7:0] src_rd;
    logic       trig;

    assign trig = ~I_DMA_REG_WE_L;

    // Page presented on the read address
`ifdef OAM_DMA_ECHO_MAP_EN
    assign src_rd = echo_map(src_hi);
`else
    assign src_rd = src_hi;
`endif

    // Next-state logic: a trigger in any state restarts the copy at index 0
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        dly_n    = dly_cnt;
        wr_vld_n = 1'b0;
        wr_idx_n = wr_idx;
        if (trig) begin
            // Clearing wr_vld here drops the write of the byte read this cycle.
            idx_n   = '0;
            dly_n   = '0;
            state_n = (START_DELAY == 0) ? XFER : START;
        end else begin
            case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                START: begin
                    if (dly_cnt == DLY_LAST) begin
                        state_n = XFER;
                        idx_n   = '0;
                    end else begin
                        dly_n = dly_cnt + 2'd1;
                    end
                end
                XFER: begin
                    wr_vld_n = 1'b1;
                    wr_idx_n = idx;
                    if (idx == LAST_IDX) begin
                        state_n = DRAIN;
                    end else begin
                        idx_n = idx + 8'd1;
                    end
                end
                DRAIN: begin
                    state_n = DONE_ST;
                end
                DONE_ST: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, counters and write pipeline registers
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state   <= IDLE;
            idx     <= '0;
            dly_cnt <= '0;
            wr_vld  <= 1'b0;
            wr_idx  <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            dly_cnt <= dly_n;
            wr_vld  <= wr_vld_n;
            wr_idx  <= wr_idx_n;
        end
    end

    // Source page register, also the CPU readback value
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            src_hi <= '0;
        end else if (trig) begin
            src_hi <= I_DMA_REG_DATA;
        end
    end

    assign O_DMA_REG_DATA = src_hi;

    // Bus strobes and addresses; returned read data passes straight to the write port
    always_comb begin
        O_RDMA_RE_L = 1'b1;
        O_RDMA_ADDR = '0;
        O_WDMA_WE_L = 1'b1;
        O_WDMA_ADDR = '0;
        O_WDMA_DATA = '0;
        if (state == XFER) begin
            O_RDMA_RE_L = 1'b0;
            O_RDMA_ADDR = {src_rd, idx};
        end
        if (wr_vld) begin
            O_WDMA_WE_L = 1'b0;
            O_WDMA_ADDR = DEST_BASE + {8'h00, wr_idx};
            O_WDMA_DATA = I_RDMA_DATA;
        end
    end

    // Busy covers the trigger cycle itself so a back-to-back trigger on DONE_ST keeps it high
    always_comb begin
        O_DMA_BUSY = ~I_RESET & (trig | (state inside {START, XFER, DRAIN}));
        O_DMA_DONE = (state == DONE_ST);
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Bench for oam_dma_engine: main instance with default geometry checked by a
// read/write scoreboard, plus a small XFER_LEN=4 / START_DELAY=0 instance
// checked cycle by cycle against a hand-written table.
module tb_oam_dma_engine;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we_l, re_l, wr_l, busy, done;
    logic [7:0]  dat, regd, rdata, wdata;
    logic [15:0] raddr, waddr;

    logic        s_we_l, s_re_l, s_wr_l, s_busy, s_done;
    logic [7:0]  s_dat, s_regd, s_rdata, s_wdata;
    logic [15:0] s_raddr, s_waddr;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];

    logic [15:0] rq[$];
    wr_t         wq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic mon_en = 1'b0;
    logic [7:0] epg;

    // Small-instance expectations, cycle 0 = trigger cycle
    logic        t_re_l  [7] = '{1, 0, 0, 0, 0, 1, 1};
    logic [15:0] t_raddr [7] = '{16'h0000, 16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h0000, 16'h0000};
    logic        t_we_l  [7] = '{1, 1, 0, 0, 0, 0, 1};
    logic [15:0] t_waddr [7] = '{16'h0000, 16'h0000, 16'hFE00, 16'hFE01, 16'hFE02, 16'hFE03, 16'h0000};
    logic [7:0]  t_wdata [7] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h00};
    logic        t_busy  [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic        t_done  [7] = '{0, 0, 0, 0, 0, 0, 1};

    oam_dma_engine u_dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_DMA_REG_WE_L (we_l),
        .I_DMA_REG_DATA (dat),
        .O_DMA_REG_DATA (regd),
        .O_RDMA_ADDR    (raddr),
        .O_RDMA_RE_L    (re_l),
        .I_RDMA_DATA    (rdata),
        .O_WDMA_ADDR    (waddr),
        .O_WDMA_DATA    (wdata),
        .O_WDMA_WE_L    (wr_l),
        .O_DMA_BUSY     (busy),
        .O_DMA_DONE     (done)
    );

    oam_dma_engine #(
        .XFER_LEN    (4),
        .DEST_BASE   (16'hFE00),
        .START_DELAY (0)
    ) u_small (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_DMA_REG_WE_L (s_we_l),
        .I_DMA_REG_DATA (s_dat),
        .O_DMA_REG_DATA (s_regd),
        .O_RDMA_ADDR    (s_raddr),
        .O_RDMA_RE_L    (s_re_l),
        .I_RDMA_DATA    (s_rdata),
        .O_WDMA_ADDR    (s_waddr),
        .O_WDMA_DATA    (s_wdata),
        .O_WDMA_WE_L    (s_wr_l),
        .O_DMA_BUSY     (s_busy),
        .O_DMA_DONE     (s_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory model: read data returns the cycle after the strobe; OAM writes captured
    always @(posedge clk) begin
        if (re_l == 1'b0) rdata <= mem[raddr];
        if (wr_l == 1'b0 && waddr[15:8] == 8'hFE) oam[waddr[7:0]] <= wdata;
        if (s_re_l == 1'b0) s_rdata <= mem[s_raddr];
    end

    // Monitor: pops the scoreboard whenever the main instance strobes
    always @(negedge clk) begin : monitor
        logic [15:0] ea;
        wr_t ew;
        if (mon_en) begin
            if (re_l == 1'b0) begin
                chk("rd_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    ea = rq.pop_front();
                    chk("rd_addr", 32'(raddr), 32'(ea));
                end
            end
            if (wr_l == 1'b0) begin
                chk("wr_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    ew = wq.pop_front();
                    chk("wr_addr", 32'(waddr), 32'(ew.a));
                    chk("wr_data", 32'(wdata), 32'(ew.d));
                end
            end
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic push_copy(input logic [7:0] pg, input int nrd, input int nwr);
        wr_t w;
        for (int i = 0; i < nrd; i++) rq.push_back({pg, 8'(i)});
        for (int i = 0; i < nwr; i++) begin
            w.a = 16'hFE00 + 16'(i);
            w.d = mem[{pg, 8'(i)}];
            wq.push_back(w);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the trigger
    task automatic trigger(input logic [7:0] pg);
        we_l = 1'b0;
        dat  = pg;
        @(posedge clk); #1;
        we_l = 1'b1;
    endtask

    task automatic wait_done(input string nm, input int budget);
        logic found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    task automatic wait_raddr(input string nm, input logic [15:0] a, input int budget);
        logic found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            if (re_l === 1'b0 && raddr === a) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    function automatic int oam_diffs(input logic [7:0] pg, input int lo, input int hi);
        int d = 0;
        for (int i = lo; i <= hi; i++) if (oam[i] !== mem[{pg, 8'(i)}]) d++;
        return d;
    endfunction

    initial begin
        int b0, d0;
        rst = 1'b1; we_l = 1'b1; dat = '0;
        s_we_l = 1'b1; s_dat = '0;
`ifdef OAM_DMA_ECHO_MAP_EN
        epg = 8'hC3;
`else
        epg = 8'hE3;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h5A;
            mem[16'hC200 + 16'(i)] = 8'(i) + 8'h30;
            mem[16'hC300 + 16'(i)] = 8'(i) ^ 8'h3C;
            mem[16'hE300 + 16'(i)] = 8'(i) ^ 8'hA5;
            mem[16'h8000 + 16'(i)] = 8'(i) + 8'h10;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_re_l", 32'(re_l), 32'd1);
        chk("rst_we_l", 32'(wr_l), 32'd1);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_regd", 32'(regd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Full copy of page C1
        push_copy(8'hC1, 160, 160);
        b0 = busy_cnt; d0 = done_cnt;
        trigger(8'hC1);
        wait_done("t1_done_seen", 400);
        @(negedge clk); #1;
        chk("t1_busy_span", 32'(busy_cnt - b0), 32'd163);
        chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t1_readback", 32'(regd), 32'hC1);
        chk("t1_oam", 32'(oam_diffs(8'hC1, 0, 159)), 32'd0);

        // Retrigger with C2 while reading index 50
        @(posedge clk); #1;
        d0 = done_cnt;
        push_copy(8'hC1, 51, 50);
        trigger(8'hC1);
        wait_raddr("t2_idx50_seen", 16'hC132, 300);
        push_copy(8'hC2, 160, 160);
        trigger(8'hC2);
        wait_done("t2_done_seen", 400);
        @(negedge clk); #1;
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t2_readback", 32'(regd), 32'hC2);
        chk("t2_oam", 32'(oam_diffs(8'hC2, 0, 159)), 32'd0);

        // Reset while reading index 80
        @(posedge clk); #1;
        d0 = done_cnt;
        push_copy(8'hC1, 81, 80);
        trigger(8'hC1);
        wait_raddr("t3_idx80_seen", 16'hC150, 300);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t3_re_l", 32'(re_l), 32'd1);
        chk("t3_we_l", 32'(wr_l), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_regd", 32'(regd), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        chk("t3_done_cnt", 32'(done_cnt - d0), 32'd0);
        chk("t3_oam_written", 32'(oam_diffs(8'hC1, 0, 79)), 32'd0);
        chk("t3_oam_untouched", 32'(oam_diffs(8'hC2, 80, 159)), 32'd0);

        // Page E3: echo-mapped or raw depending on the build
        @(posedge clk); #1;
        d0 = done_cnt;
        push_copy(epg, 160, 160);
        trigger(8'hE3);
        wait_done("t4_done_seen", 400);
        @(negedge clk); #1;
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t4_readback", 32'(regd), 32'hE3);
        chk("t4_oam", 32'(oam_diffs(epg, 0, 159)), 32'd0);

        // Trigger in the DONE_ST cycle
        @(posedge clk); #1;
        d0 = done_cnt;
        push_copy(8'hC1, 160, 160);
        trigger(8'hC1);
        wait_done("t5_first_done", 400);
        push_copy(8'hC2, 160, 160);
        we_l = 1'b0;
        dat  = 8'hC2;
        @(negedge clk);
        chk("t5_busy_hold", 32'(busy), 32'd1);
        chk("t5_done_pulse", 32'(done), 32'd1);
        @(posedge clk); #1;
        we_l = 1'b1;
        wait_done("t5_second_done", 400);
        @(negedge clk); #1;
        chk("t5_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("t5_readback", 32'(regd), 32'hC2);
        chk("t5_oam", 32'(oam_diffs(8'hC2, 0, 159)), 32'd0);

        // Small instance: XFER_LEN=4, START_DELAY=0, page 80
        @(posedge clk); #1;
        s_we_l = 1'b0;
        s_dat  = 8'h80;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("s_re_l_c%0d", c), 32'(s_re_l), 32'(t_re_l[c]));
            chk($sformatf("s_raddr_c%0d", c), 32'(s_raddr), 32'(t_raddr[c]));
            chk($sformatf("s_we_l_c%0d", c), 32'(s_wr_l), 32'(t_we_l[c]));
            chk($sformatf("s_waddr_c%0d", c), 32'(s_waddr), 32'(t_waddr[c]));
            chk($sformatf("s_wdata_c%0d", c), 32'(s_wdata), 32'(t_wdata[c]));
            chk($sformatf("s_busy_c%0d", c), 32'(s_busy), 32'(t_busy[c]));
            chk($sformatf("s_done_c%0d", c), 32'(s_done), 32'(t_done[c]));
            @(posedge clk); #1;
            s_we_l = 1'b1;
        end
        chk("s_readback", 32'(s_regd), 32'h80);

        // Scoreboard must be drained
        chk("rd_queue_left", 32'(rq.size()), 32'd0);
        chk("wr_queue_left", 32'(wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
